// File: rtl/rvfi_check_sequencer_if.sv
// Bundle of RVFI retire lanes and checker control signals used by rvfi_check_sequencer.
//   rvfi_valid   : per-lane retire valid (NRET bits), driven by the core side
//   core_reset   : checker reset
//   trig / check : single-cycle trigger and check pulses
//   cycle        : current cycle count (8 bits)
//   retire_cnt   : retirements counted since trig (8 bits)
//   done/timeout : sticky status
//   ext_trig/ext_check : external controls, present only with RISCV_FORMAL_SEQ_EXTCTRL_EN
// master = testbench/core side, slave = sequencer.
interface rvfi_check_sequencer_if #(
  parameter int unsigned NRET = 1
) ();
  logic [NRET-1:0] rvfi_valid;
  logic            core_reset;
  logic            trig;
  logic            check;
  logic [7:0]      cycle;
  logic [7:0]      retire_cnt;
  logic            done;
  logic            timeout;
`ifdef RISCV_FORMAL_SEQ_EXTCTRL_EN
  logic            ext_trig;
  logic            ext_check;

  modport master (
    output rvfi_valid, ext_trig, ext_check,
    input  core_reset, trig, check, cycle, retire_cnt, done, timeout
  );
  modport slave (
    input  rvfi_valid, ext_trig, ext_check,
    output core_reset, trig, check, cycle, retire_cnt, done, timeout
  );
`else
  modport master (
    output rvfi_valid,
    input  core_reset, trig, check, cycle, retire_cnt, done, timeout
  );
  modport slave (
    input  rvfi_valid,
    output core_reset, trig, check, cycle, retire_cnt, done, timeout
  );
`endif
endinterface

// File: rtl/rvfi_check_sequencer.sv
// Scheduler for the formal testbench: derives the checker's core_reset, trig and
// check controls from a saturating cycle counter and RVFI retirement activity.
// Ports:
//   clock  : testbench clock
//   reset  : synchronous, active-high reset
//   bus    : rvfi_check_sequencer_if.slave (rvfi_valid in; core_reset, trig, check,
//            cycle, retire_cnt, done, timeout out)
// Optional feature macro: RISCV_FORMAL_SEQ_EXTCTRL_EN
//   When defined, trig/check timing comes from bus.ext_trig / bus.ext_check and the
//   cycle-255 timeout is disabled.
module rvfi_check_sequencer #(
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned TRIG_CYCLE   = 10,
  parameter int unsigned CHECK_CYCLE  = 15,
  parameter int unsigned NRET         = 1,
  parameter int unsigned MIN_RETIRE   = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  rvfi_check_sequencer_if.slave  bus
);

  localparam int unsigned CW      = 8;
  localparam logic [CW-1:0] CMAX  = '1;

  // Elaboration-time parameter sanity checks
  if (RESET_CYCLES < 1) begin : g_chk_reset_cycles
    $error("rvfi_check_sequencer: RESET_CYCLES must be >= 1");
  end
  if (TRIG_CYCLE < RESET_CYCLES) begin : g_chk_trig_cycle
    $error("rvfi_check_sequencer: TRIG_CYCLE must be >= RESET_CYCLES");
  end
  if ((CHECK_CYCLE < TRIG_CYCLE) || (CHECK_CYCLE > 254)) begin : g_chk_check_cycle
    $error("rvfi_check_sequencer: CHECK_CYCLE must lie in [TRIG_CYCLE, 254]");
  end
  if (MIN_RETIRE > 255) begin : g_chk_min_retire
    $error("rvfi_check_sequencer: MIN_RETIRE must be <= 255");
  end
  if (NRET < 1) begin : g_chk_nret
    $error("rvfi_check_sequencer: NRET must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cycle_q;
  logic [CW-1:0] retire_cnt_q;
  logic          done_q;
  logic          timeout_q;
  logic          timeout_set;

  logic [CW-1:0] cycle_c;
  logic          core_reset_c;
  logic          trig_c;
  logic          check_c;
  logic          window_c;
  logic          cycle_ok_c;
  logic [31:0]   retire_now_c;
  logic [31:0]   retire_sum_c;
  logic [CW-1:0] retire_total_c;

  // Cycle output is forced to zero while reset is held
  assign cycle_c      = reset ? '0 : cycle_q;
  assign core_reset_c = (32'(cycle_c) < RESET_CYCLES);

  // Saturating cycle counter
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q <= '0;
    end else if (cycle_q != CMAX) begin
      cycle_q <= cycle_q + CW'(1);
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output / datapath combinational process
  always_comb begin
    trig_c         = 1'b0;
    check_c        = 1'b0;
    window_c       = 1'b0;
    cycle_ok_c     = 1'b0;
    retire_now_c   = '0;
    retire_sum_c   = '0;
    retire_total_c = retire_cnt_q;

`ifdef RISCV_FORMAL_SEQ_EXTCTRL_EN
    trig_c     = (state_q == S_IDLE) && bus.ext_trig && !core_reset_c && !reset;
    cycle_ok_c = bus.ext_check;
`else
    trig_c     = (state_q == S_IDLE) && (32'(cycle_c) == TRIG_CYCLE) && !reset;
    cycle_ok_c = (32'(cycle_c) >= CHECK_CYCLE);
`endif

    // Retirements only count on the trig cycle and while armed
    window_c = trig_c || (state_q == S_ARMED);

    for (int unsigned i = 0; i < NRET; i++) begin
      retire_now_c = retire_now_c + 32'(bus.rvfi_valid[i]);
    end

    // Wide sum so that many lanes retiring at once cannot wrap before saturation
    retire_sum_c   = 32'(retire_cnt_q) + (window_c ? retire_now_c : 32'd0);
    retire_total_c = (retire_sum_c > 32'(CMAX)) ? CMAX : CW'(retire_sum_c);

    check_c = window_c && cycle_ok_c && (32'(retire_total_c) >= MIN_RETIRE) && !reset;
  end

  // Next-state process
  always_comb begin
    state_d     = state_q;
    timeout_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (trig_c) begin
          state_d = check_c ? S_DONE : S_ARMED;
        end
      end
      S_ARMED: begin
        if (check_c) begin
          state_d = S_DONE;
`ifndef RISCV_FORMAL_SEQ_EXTCTRL_EN
        end else if (cycle_c == CMAX) begin
          // Counter saturated with no check: give up
          state_d     = S_DONE;
          timeout_set = 1'b1;
`endif
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Retire counter and sticky status
  always_ff @(posedge clock) begin
    if (reset) begin
      retire_cnt_q <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      if (window_c) begin
        retire_cnt_q <= retire_total_c;
      end
      done_q    <= (state_d == S_DONE);
      timeout_q <= timeout_q | timeout_set;
    end
  end

  assign bus.core_reset = core_reset_c;
  assign bus.trig       = trig_c;
  assign bus.check      = check_c;
  assign bus.cycle      = cycle_c;
  assign bus.retire_cnt = retire_cnt_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Self-checking bench for rvfi_check_sequencer: four configurations share one clock,
// each exercised by directed steps; expectations go through a scoreboard queue.
module tb_rvfi_check_sequencer;

  typedef struct packed {
    logic [7:0] cyc;
    logic       cr;
    logic       trig;
    logic       check;
    logic       done;
    logic       timeout;
    logic [7:0] rc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;
  logic rst_d = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  rvfi_check_sequencer_if #(.NRET(1)) if_a ();
  rvfi_check_sequencer_if #(.NRET(2)) if_b ();
  rvfi_check_sequencer_if #(.NRET(1)) if_c ();
  rvfi_check_sequencer_if #(.NRET(4)) if_d ();

  // A: defaults
  rvfi_check_sequencer u_a (.clock(clk), .reset(rst_a), .bus(if_a));
  // B: two lanes, three retirements required
  rvfi_check_sequencer #(.NRET(2), .MIN_RETIRE(3)) u_b (.clock(clk), .reset(rst_b), .bus(if_b));
  // C: trig and check on the same cycle
  rvfi_check_sequencer #(.TRIG_CYCLE(5), .CHECK_CYCLE(5)) u_c (.clock(clk), .reset(rst_c), .bus(if_c));
  // D: four lanes, saturating retire gate
  rvfi_check_sequencer #(.NRET(4), .MIN_RETIRE(255)) u_d (.clock(clk), .reset(rst_d), .bus(if_d));

  function automatic exp_t mk(int cyc, bit cr, bit trig, bit check, bit done, bit timeout, int rc);
    exp_t e;
    e.cyc     = 8'((cyc > 255) ? 255 : cyc);
    e.cr      = cr;
    e.trig    = trig;
    e.check   = check;
    e.done    = done;
    e.timeout = timeout;
    e.rc      = 8'((rc > 255) ? 255 : rc);
    return e;
  endfunction

  function automatic exp_t obs(int sel);
    exp_t e;
    case (sel)
      0: e = {if_a.cycle, if_a.core_reset, if_a.trig, if_a.check, if_a.done, if_a.timeout, if_a.retire_cnt};
      1: e = {if_b.cycle, if_b.core_reset, if_b.trig, if_b.check, if_b.done, if_b.timeout, if_b.retire_cnt};
      2: e = {if_c.cycle, if_c.core_reset, if_c.trig, if_c.check, if_c.done, if_c.timeout, if_c.retire_cnt};
      default: e = {if_d.cycle, if_d.core_reset, if_d.trig, if_d.check, if_d.done, if_d.timeout, if_d.retire_cnt};
    endcase
    return e;
  endfunction

  // One clock: drive inputs after the falling edge, then sample and score
  task automatic step(input int sel, input logic rst, input logic [3:0] valid,
                      input bit chk, input exp_t e, input string tag, input int k);
    exp_t want;
    exp_t got;
    @(negedge clk);
    case (sel)
      0: begin rst_a = rst; if_a.rvfi_valid = valid[0:0]; end
      1: begin rst_b = rst; if_b.rvfi_valid = valid[1:0]; end
      2: begin rst_c = rst; if_c.rvfi_valid = valid[0:0]; end
      default: begin rst_d = rst; if_d.rvfi_valid = valid; end
    endcase
    if (chk) sb_q.push_back(e);
    #1;
    if (chk) begin
      want = sb_q.pop_front();
      got  = obs(sel);
      n_cmp++;
      assert (got === want) else begin
        n_bad++;
        $error("FAIL %s k=%0d observed cyc=%0d cr=%b trig=%b check=%b done=%b to=%b rc=%0d expected cyc=%0d cr=%b trig=%b check=%b done=%b to=%b rc=%0d",
               tag, k, got.cyc, got.cr, got.trig, got.check, got.done, got.timeout, got.rc,
               want.cyc, want.cr, want.trig, want.check, want.done, want.timeout, want.rc);
      end
    end
  endtask

  // Two reset clocks; the second must show a fully cleared sequencer
  task automatic do_reset(input int sel, input string tag);
    step(sel, 1'b1, 4'h0, 1'b0, mk(0, 1, 0, 0, 0, 0, 0), tag, 0);
    step(sel, 1'b1, 4'h0, 1'b1, mk(0, 1, 0, 0, 0, 0, 0), tag, 0);
  endtask

  initial begin
    logic [3:0] v;
    if_a.rvfi_valid = '0;
    if_b.rvfi_valid = '0;
    if_c.rvfi_valid = '0;
    if_d.rvfi_valid = '0;

    // A: reset state, then default trig/check timing
    step(0, 1'b1, 4'h0, 1'b1, mk(0, 1, 0, 0, 0, 0, 0), "a_reset", 0);
    for (int k = 0; k <= 20; k++)
      step(0, 1'b0, 4'h0, 1'b1, mk(k, k < 1, k == 10, k == 15, k >= 16, 0, 0), "a_run", k);

    // A: reset reasserted while armed clears everything and restarts
    do_reset(0, "a_reset2");
    for (int k = 0; k <= 11; k++)
      step(0, 1'b0, 4'h0, 1'b1, mk(k, k < 1, k == 10, 0, 0, 0, 0), "a_pre", k);
    step(0, 1'b1, 4'h0, 1'b1, mk(0, 1, 0, 0, 0, 0, 0), "a_midreset", 12);
    for (int k = 0; k <= 17; k++)
      step(0, 1'b0, 4'h0, 1'b1, mk(k, k < 1, k == 10, k == 15, k >= 16, 0, 0), "a_restart", k);

    // B: retire gate never met, counter saturates and times out
    do_reset(1, "b_reset");
    for (int k = 0; k <= 258; k++) begin
      v = (k == 10) ? 4'h3 : 4'h0;
      step(1, 1'b0, v, 1'b1,
           mk(k, k < 1, k == 10, 0, k >= 256, k >= 256, (k >= 11) ? 2 : 0), "b_timeout", k);
    end

    // B: third retirement at cycle 20 releases check; valid ignored in IDLE and DONE
    do_reset(1, "b_reset2");
    for (int k = 0; k <= 26; k++) begin
      case (k)
        5, 10, 23: v = 4'h3;
        20:        v = 4'h1;
        default:   v = 4'h0;
      endcase
      step(1, 1'b0, v, 1'b1,
           mk(k, k < 1, k == 10, k == 20, k >= 21, 0, (k >= 21) ? 3 : ((k >= 11) ? 2 : 0)),
           "b_gate", k);
    end

    // C: trig and check coincide, straight to DONE
    do_reset(2, "c_reset");
    for (int k = 0; k <= 9; k++)
      step(2, 1'b0, 4'h0, 1'b1, mk(k, k < 1, k == 5, k == 5, k >= 6, 0, 0), "c_same", k);

    // D: retire count saturates at 255 within a four-lane cycle; cycle saturates too
    do_reset(3, "d_reset");
    for (int k = 0; k <= 259; k++)
      step(3, 1'b0, 4'hF, 1'b1,
           mk(k, k < 1, k == 10, k == 73, k >= 74, 0, (k <= 10) ? 0 : 4 * (k - 10)),
           "d_sat", k);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
